bin2bcd_dabble: RTL and testbench

Parametrised, sequential binary-to-BCD converter using the shift-and-add-3 (double-dabble) algorithm. It performs one bit-step per clock and publishes the result through a start/done handshake. It replaces the combinational divide/modulo converter in the display datapath, e.g. between the temperature ROM and the seven-segment driver, for operands wider than 8 bits. It also adds signed-magnitude conversion and overflow reporting.

---
 rtl/bin2bcd_dabble.sv | 104 ++++++++++
 tb/tb_bin2bcd_dabble.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bin2bcd_dabble.sv
// Sequential binary-to-BCD converter (shift-and-add-3).
// One bit per clock, signed-magnitude input, sticky overflow flag.
module bin2bcd_dabble #(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 3
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic                signed_mode,
  input  logic [BIN_W-1:0]    bin,
  output logic                busy,
  output logic                done,
  output logic [4*DIGITS-1:0] bcd,
  output logic                neg,
  output logic                overflow
);

  localparam int SW = 4 * DIGITS;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  localparam logic [5:0] LAST = 6'(BIN_W - 1);

  logic [1:0]       state;
  logic [BIN_W-1:0] mag;
  logic [BIN_W-1:0] mag_in;
  logic [SW-1:0]    scr;
  logic [SW-1:0]    adj;
  logic [5:0]       cnt;
  logic             ovf_acc;
  logic             neg_acc;
  logic             is_neg;

  assign is_neg = signed_mode & bin[BIN_W-1];
  assign mag_in = is_neg ? (~bin) + BIN_W'(1) : bin;

  // Add 3 to every scratch digit that will reach 10+ after the shift.
  always_comb begin
    adj = scr;
    for (int k = 0; k < DIGITS; k++) begin
      if (scr[4*k +: 4] >= 4'd5) begin
        adj[4*k +: 4] = scr[4*k +: 4] + 4'd3;
      end
    end
  end

  // Control FSM, shift datapath and registered result outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= S_IDLE;
      mag      <= '0;
      scr      <= '0;
      cnt      <= '0;
      ovf_acc  <= 1'b0;
      neg_acc  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      bcd      <= '0;
      neg      <= 1'b0;
      overflow <= 1'b0;
    end else begin
      done <= 1'b0;
      if (done) begin
        busy <= 1'b0;
      end
      case (state)
        S_IDLE: begin
          if (start && !busy) begin
            mag     <= mag_in;
            neg_acc <= is_neg;
            scr     <= '0;
            cnt     <= '0;
            ovf_acc <= 1'b0;
            busy    <= 1'b1;
            state   <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          scr <= {adj[SW-2:0], mag[BIN_W-1]};
          mag <= {mag[BIN_W-2:0], 1'b0};
          if (adj[SW-1]) begin
            ovf_acc <= 1'b1;
          end
          cnt <= cnt + 6'd1;
          if (cnt == LAST) begin
            state <= S_DONE;
          end
        end
        S_DONE: begin
          bcd      <= scr;
          neg      <= neg_acc;
          overflow <= ovf_acc;
          done     <= 1'b1;
          state    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bin2bcd_dabble.sv
// Scoreboard bench for bin2bcd_dabble.
// Three configurations: 8b/3 digits, 8b/2 digits, 16b/5 digits.
module tb_bin2bcd_dabble;

  localparam int BW[3] = '{8, 8, 16};
  localparam int DG[3] = '{3, 2, 5};

  typedef struct {
    logic [39:0] bcd;
    logic        neg;
    logic        ovf;
    longint      due;
  } exp_t;

  typedef struct {
    int          g;
    logic        sm;
    logic [31:0] b;
    logic [39:0] xb;
    logic        xn;
    logic        xo;
    logic        noise;
  } dir_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start[3];
  logic        sgn[3];
  logic [31:0] bin_a[3];
  logic        busy_a[3];
  logic        done_a[3];
  logic        neg_a[3];
  logic        ovf_a[3];
  logic [39:0] bcd_a[3];

  logic        b0, d0, n0, o0;
  logic        b1, d1, n1, o1;
  logic        b2, d2, n2, o2;
  logic [11:0] c0;
  logic [7:0]  c1;
  logic [19:0] c2;

  exp_t   q[3][$];
  longint e0[3];
  longint cyc;
  int     tests;
  int     errs;

  assign busy_a[0] = b0;
  assign busy_a[1] = b1;
  assign busy_a[2] = b2;
  assign done_a[0] = d0;
  assign done_a[1] = d1;
  assign done_a[2] = d2;
  assign neg_a[0]  = n0;
  assign neg_a[1]  = n1;
  assign neg_a[2]  = n2;
  assign ovf_a[0]  = o0;
  assign ovf_a[1]  = o1;
  assign ovf_a[2]  = o2;
  assign bcd_a[0]  = 40'(c0);
  assign bcd_a[1]  = 40'(c1);
  assign bcd_a[2]  = 40'(c2);

  bin2bcd_dabble #(.BIN_W(8), .DIGITS(3)) u0 (
    .clk(clk), .reset_n(reset_n), .start(start[0]),
    .signed_mode(sgn[0]), .bin(bin_a[0][7:0]),
    .busy(b0), .done(d0), .bcd(c0), .neg(n0), .overflow(o0)
  );

  bin2bcd_dabble #(.BIN_W(8), .DIGITS(2)) u1 (
    .clk(clk), .reset_n(reset_n), .start(start[1]),
    .signed_mode(sgn[1]), .bin(bin_a[1][7:0]),
    .busy(b1), .done(d1), .bcd(c1), .neg(n1), .overflow(o1)
  );

  bin2bcd_dabble #(.BIN_W(16), .DIGITS(5)) u2 (
    .clk(clk), .reset_n(reset_n), .start(start[2]),
    .signed_mode(sgn[2]), .bin(bin_a[2][15:0]),
    .busy(b2), .done(d2), .bcd(c2), .neg(n2), .overflow(o2)
  );

  always #5 clk = ~clk;

  task automatic chk(string nm, logic [39:0] act, logic [39:0] exp);
    tests++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic exp_t model(int g, logic sm, logic [31:0] b,
                                 longint due);
    exp_t x;
    longint unsigned v, m, lim;
    v = 64'(b) & ((64'd1 << BW[g]) - 64'd1);
    x.neg = sm && (v >= (64'd1 << (BW[g] - 1)));
    m = x.neg ? (64'd1 << BW[g]) - v : v;
    lim = 1;
    for (int k = 0; k < DG[g]; k++) lim = lim * 10;
    x.ovf = (m >= lim);
    x.bcd = '0;
    for (int k = 0; k < DG[g]; k++) begin
      x.bcd[4*k +: 4] = 4'(m % 10);
      m = m / 10;
    end
    x.due = due;
    return x;
  endfunction

  // Accept model: a start is taken only when the converter is idle.
  always @(posedge clk) begin
    for (int g = 0; g < 3; g++) begin
      longint e;
      e = cyc + 1;
      if (reset_n === 1'b1 && start[g] === 1'b1 &&
          e > e0[g] + BW[g] + 2) begin
        e0[g] = e;
        q[g].push_back(model(g, sgn[g], bin_a[g], e + BW[g] + 1));
      end
    end
  end

  // Monitor: busy window, done pulses against the scoreboard.
  always @(negedge clk) begin
    cyc = cyc + 1;
    for (int g = 0; g < 3; g++) begin
      logic bexp;
      bexp = (reset_n === 1'b1) && (cyc >= e0[g]) &&
             (cyc <= e0[g] + BW[g] + 1);
      chk($sformatf("busy%0d@%0d", g, cyc), 40'(busy_a[g]), 40'(bexp));
      if (done_a[g] !== 1'b0) begin
        if (q[g].size() == 0) begin
          tests++;
          errs++;
          $display("FAIL done%0d@%0d: got unexpected done expected none",
                   g, cyc);
        end else begin
          exp_t x;
          x = q[g].pop_front();
          chk($sformatf("bcd%0d", g), bcd_a[g], x.bcd);
          chk($sformatf("neg%0d", g), 40'(neg_a[g]), 40'(x.neg));
          chk($sformatf("ovf%0d", g), 40'(ovf_a[g]), 40'(x.ovf));
          chk($sformatf("latency%0d", g), 40'(cyc), 40'(x.due));
        end
      end
      if (q[g].size() != 0 && cyc > q[g][0].due) begin
        tests++;
        errs++;
        $display("FAIL missing_done%0d@%0d: got none expected due %0d",
                 g, cyc, q[g][0].due);
        void'(q[g].pop_front());
      end
    end
  end

  task automatic go(int g, logic sm, logic [31:0] b, logic noise);
    @(posedge clk); #2;
    start[g] = 1'b1;
    sgn[g]   = sm;
    bin_a[g] = b;
    @(posedge clk); #2;
    start[g] = 1'b0;
    for (int i = 0; i <= BW[g] + 1; i++) begin
      @(posedge clk); #2;
      start[g] = noise && (i == 2 || i == BW[g]);
      if (start[g]) bin_a[g] = $urandom;
    end
    start[g] = 1'b0;
  endtask

  dir_t tbl[11] = '{
    '{0, 1'b0, 32'hFF,   40'h255,   1'b0, 1'b0, 1'b0},
    '{0, 1'b0, 32'h0,    40'h000,   1'b0, 1'b0, 1'b0},
    '{0, 1'b0, 32'd9,    40'h009,   1'b0, 1'b0, 1'b0},
    '{0, 1'b0, 32'd100,  40'h100,   1'b0, 1'b0, 1'b0},
    '{0, 1'b1, 32'h80,   40'h128,   1'b1, 1'b0, 1'b0},
    '{0, 1'b1, 32'hFF,   40'h001,   1'b1, 1'b0, 1'b0},
    '{0, 1'b1, 32'h7F,   40'h127,   1'b0, 1'b0, 1'b0},
    '{1, 1'b0, 32'd100,  40'h00,    1'b0, 1'b1, 1'b0},
    '{1, 1'b0, 32'd99,   40'h99,    1'b0, 1'b0, 1'b0},
    '{2, 1'b0, 32'hFFFF, 40'h65535, 1'b0, 1'b0, 1'b1},
    '{2, 1'b1, 32'h8000, 40'h32768, 1'b1, 1'b0, 1'b1}
  };

  initial begin
    tests   = 0;
    errs    = 0;
    cyc     = 0;
    reset_n = 1'b0;
    for (int g = 0; g < 3; g++) begin
      start[g] = 1'b0;
      sgn[g]   = 1'b0;
      bin_a[g] = '0;
      e0[g]    = -1000;
    end
    repeat (3) @(posedge clk);
    #2;
    for (int g = 0; g < 3; g++) begin
      chk($sformatf("rst_bcd%0d", g), bcd_a[g], 40'h0);
      chk($sformatf("rst_neg%0d", g), 40'(neg_a[g]), 40'h0);
      chk($sformatf("rst_ovf%0d", g), 40'(ovf_a[g]), 40'h0);
      chk($sformatf("rst_done%0d", g), 40'(done_a[g]), 40'h0);
    end
    reset_n = 1'b1;

    foreach (tbl[i]) begin
      go(tbl[i].g, tbl[i].sm, tbl[i].b, tbl[i].noise);
      chk($sformatf("dir%0d_bcd", i), bcd_a[tbl[i].g], tbl[i].xb);
      chk($sformatf("dir%0d_neg", i), 40'(neg_a[tbl[i].g]),
          40'(tbl[i].xn));
      chk($sformatf("dir%0d_ovf", i), 40'(ovf_a[tbl[i].g]),
          40'(tbl[i].xo));
    end

    @(posedge clk); #2;
    start[0] = 1'b1;
    sgn[0]   = 1'b0;
    bin_a[0] = 32'd200;
    @(posedge clk); #2;
    start[0] = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    reset_n = 1'b0;
    for (int g = 0; g < 3; g++) begin
      q[g].delete();
      e0[g] = -1000;
    end
    #1;
    for (int g = 0; g < 3; g++) begin
      chk($sformatf("mid_rst_busy%0d", g), 40'(busy_a[g]), 40'h0);
      chk($sformatf("mid_rst_bcd%0d", g), bcd_a[g], 40'h0);
      chk($sformatf("mid_rst_neg%0d", g), 40'(neg_a[g]), 40'h0);
      chk($sformatf("mid_rst_done%0d", g), 40'(done_a[g]), 40'h0);
    end
    repeat (2) @(posedge clk);
    #2;
    reset_n = 1'b1;
    go(0, 1'b0, 32'd42, 1'b0);
    chk("post_rst_bcd", bcd_a[0], 40'h042);

    repeat (600) begin
      @(posedge clk); #2;
      for (int g = 0; g < 3; g++) begin
        start[g] = ($urandom_range(0, 2) == 0);
        sgn[g]   = 1'($urandom_range(0, 1));
        case ($urandom_range(0, 9))
          0:       bin_a[g] = 32'h0;
          1:       bin_a[g] = 32'hFFFF_FFFF;
          2:       bin_a[g] = 32'h1 << (BW[g] - 1);
          default: bin_a[g] = $urandom;
        endcase
      end
    end
    @(posedge clk); #2;
    for (int g = 0; g < 3; g++) start[g] = 1'b0;

    begin
      int w;
      w = 0;
      while ((q[0].size() + q[1].size() + q[2].size()) != 0 && w < 60) begin
        @(posedge clk);
        w++;
      end
      if ((q[0].size() + q[1].size() + q[2].size()) != 0) begin
        tests++;
        errs++;
        $display("FAIL drain: got %0d pending expected 0",
                 q[0].size() + q[1].size() + q[2].size());
      end
    end
    repeat (3) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, errs);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
